// File: rtl/sram_arb_pkg.sv
// Shared types and default sizing for the SRAM port arbiter.
package sram_arb_pkg;

    typedef enum logic [1:0] {IDLE, ACCESS, TURN} state_e;
    typedef enum logic {PORT_I, PORT_D} port_e;

    localparam int DEF_ADDR_W        = 20;
    localparam int DEF_DATA_W        = 32;
    localparam int DEF_ACCESS_CYCLES = 2;
    localparam int DEF_DPRIO         = 1;

endpackage

// File: rtl/sram_rr_arbiter.sv
// Two-way selector: fixed D priority, or round-robin against the last grant.
module sram_rr_arbiter
    import sram_arb_pkg::*;
#(
    parameter int DPRIO = DEF_DPRIO
) (
    input  logic [1:0] req,         // bit 0 = I, bit 1 = D
    input  port_e      last_grant,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = ((DPRIO != 0) || (last_grant == PORT_I)) ? 2'b10 : 2'b01;
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares the single-ported SRAM between the fetch (I) and data (D) ports,
// holding each request for ACCESS_CYCLES and returning a completion pulse.
module sram_port_arbiter
    import sram_arb_pkg::*;
#(
    parameter int ADDR_W        = DEF_ADDR_W,
    parameter int DATA_W        = DEF_DATA_W,
    parameter int ACCESS_CYCLES = DEF_ACCESS_CYCLES,
    parameter int DPRIO         = DEF_DPRIO
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic                  i_req,
    input  logic [ADDR_W-1:0]     i_addr,
    output logic                  i_ready,
    output logic                  i_rvalid,
    output logic [DATA_W-1:0]     i_rdata,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_W-1:0]     d_addr,
    input  logic [DATA_W-1:0]     d_wdata,
    input  logic [DATA_W/8-1:0]   d_wmask,
    output logic                  d_ready,
    output logic                  d_rvalid,
    output logic                  d_bvalid,
    output logic [DATA_W-1:0]     d_rdata,
    output logic                  io_sram_en,
    output logic                  io_sram_we,
    output logic [ADDR_W-1:0]     io_sram_addr,
    output logic [DATA_W-1:0]     io_sram_din,
    output logic [DATA_W/8-1:0]   io_sram_wmask,
    input  logic [DATA_W-1:0]     io_sram_dout
);

    localparam int MASK_W = DATA_W / 8;
    localparam int CNT_W  = $clog2(ACCESS_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ACCESS_CYCLES - 1);

    generate
        if (ACCESS_CYCLES < 1) begin : g_bad_access_cycles
            $error("sram_port_arbiter: ACCESS_CYCLES must be at least 1");
        end
    endgenerate

    state_e              state_reg, state_next;
    logic [CNT_W-1:0]    cnt_reg, cnt_next;
    port_e               owner_reg, last_grant_reg;
    logic                en_reg, we_reg;
    logic [ADDR_W-1:0]   addr_reg;
    logic [DATA_W-1:0]   din_reg, i_rdata_reg, d_rdata_reg;
    logic [MASK_W-1:0]   wmask_reg;
    logic                i_rvalid_reg, d_rvalid_reg, d_bvalid_reg;
    logic [1:0]          req_vec, grant, ready_vec;
    logic                accept, accept_d, done;

    assign req_vec = {d_req, i_req};

    sram_rr_arbiter #(.DPRIO(DPRIO)) u_arb (
        .req        (req_vec),
        .last_grant (last_grant_reg),
        .grant      (grant)
    );

    // Grants are only honoured while the bus is idle.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_ready
            assign ready_vec[gi] = (state_reg == IDLE) && grant[gi];
        end
    endgenerate

    assign i_ready  = ready_vec[0];
    assign d_ready  = ready_vec[1];
    assign accept   = |ready_vec;
    assign accept_d = ready_vec[1];

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        done       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    state_next = ACCESS;
                    cnt_next   = CNT_LOAD;
                end
            end
            ACCESS: begin
                if (cnt_reg == '0) begin
                    done       = 1'b1;
                    state_next = we_reg ? TURN : IDLE;
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            TURN:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_reg      <= IDLE;
            cnt_reg        <= '0;
            owner_reg      <= PORT_I;
            last_grant_reg <= PORT_D;
            en_reg         <= 1'b0;
            we_reg         <= 1'b0;
            addr_reg       <= '0;
            din_reg        <= '0;
            wmask_reg      <= '0;
            i_rdata_reg    <= '0;
            d_rdata_reg    <= '0;
            i_rvalid_reg   <= 1'b0;
            d_rvalid_reg   <= 1'b0;
            d_bvalid_reg   <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            i_rvalid_reg <= 1'b0;
            d_rvalid_reg <= 1'b0;
            d_bvalid_reg <= 1'b0;
            if (accept) begin
                owner_reg      <= accept_d ? PORT_D : PORT_I;
                last_grant_reg <= accept_d ? PORT_D : PORT_I;
                en_reg         <= 1'b1;
                we_reg         <= accept_d && d_we;
                addr_reg       <= accept_d ? d_addr : i_addr;
                din_reg        <= (accept_d && d_we) ? d_wdata : '0;
                wmask_reg      <= (accept_d && d_we) ? d_wmask : '0;
            end else if (done) begin
                // Last ACCESS cycle: release the bus and signal the owner.
                en_reg    <= 1'b0;
                we_reg    <= 1'b0;
                addr_reg  <= '0;
                din_reg   <= '0;
                wmask_reg <= '0;
                if (we_reg) begin
                    d_bvalid_reg <= 1'b1;
                end else if (owner_reg == PORT_D) begin
                    d_rvalid_reg <= 1'b1;
                    d_rdata_reg  <= io_sram_dout;
                end else begin
                    i_rvalid_reg <= 1'b1;
                    i_rdata_reg  <= io_sram_dout;
                end
            end
        end
    end

    assign io_sram_en    = en_reg;
    assign io_sram_we    = we_reg;
    assign io_sram_addr  = addr_reg;
    assign io_sram_din   = din_reg;
    assign io_sram_wmask = wmask_reg;
    assign i_rvalid      = i_rvalid_reg;
    assign i_rdata       = i_rdata_reg;
    assign d_rvalid      = d_rvalid_reg;
    assign d_bvalid      = d_bvalid_reg;
    assign d_rdata       = d_rdata_reg;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter: instance A has fixed D priority,
// instance B runs round-robin; completions are matched against a scoreboard.
module tb_sram_port_arbiter;

    typedef struct {
        logic        port;   // 0 = I, 1 = D
        logic        we;
        logic [31:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Instance A signals (DPRIO = 1)
    logic        a_i_req = 0, a_d_req = 0, a_d_we = 0;
    logic [19:0] a_i_addr = 0, a_d_addr = 0;
    logic [31:0] a_d_wdata = 0;
    logic [3:0]  a_d_wmask = 0;
    logic        a_i_ready, a_i_rvalid, a_d_ready, a_d_rvalid, a_d_bvalid;
    logic [31:0] a_i_rdata, a_d_rdata;
    logic        a_en, a_we;
    logic [19:0] a_addr;
    logic [31:0] a_din, a_dout;
    logic [3:0]  a_wmask;

    // Instance B signals (DPRIO = 0)
    logic        b_i_req = 0, b_d_req = 0, b_d_we = 0;
    logic [19:0] b_i_addr = 0, b_d_addr = 0;
    logic [31:0] b_d_wdata = 0;
    logic [3:0]  b_d_wmask = 0;
    logic        b_i_ready, b_i_rvalid, b_d_ready, b_d_rvalid, b_d_bvalid;
    logic [31:0] b_i_rdata, b_d_rdata;
    logic        b_en, b_we;
    logic [19:0] b_addr;
    logic [31:0] b_din, b_dout;
    logic [3:0]  b_wmask;

    sram_port_arbiter #(.ADDR_W(20), .DATA_W(32), .ACCESS_CYCLES(2), .DPRIO(1)) u_dut_a (
        .clock(clk), .resetn(resetn),
        .i_req(a_i_req), .i_addr(a_i_addr), .i_ready(a_i_ready),
        .i_rvalid(a_i_rvalid), .i_rdata(a_i_rdata),
        .d_req(a_d_req), .d_we(a_d_we), .d_addr(a_d_addr), .d_wdata(a_d_wdata),
        .d_wmask(a_d_wmask), .d_ready(a_d_ready), .d_rvalid(a_d_rvalid),
        .d_bvalid(a_d_bvalid), .d_rdata(a_d_rdata),
        .io_sram_en(a_en), .io_sram_we(a_we), .io_sram_addr(a_addr),
        .io_sram_din(a_din), .io_sram_wmask(a_wmask), .io_sram_dout(a_dout)
    );

    sram_port_arbiter #(.ADDR_W(20), .DATA_W(32), .ACCESS_CYCLES(2), .DPRIO(0)) u_dut_b (
        .clock(clk), .resetn(resetn),
        .i_req(b_i_req), .i_addr(b_i_addr), .i_ready(b_i_ready),
        .i_rvalid(b_i_rvalid), .i_rdata(b_i_rdata),
        .d_req(b_d_req), .d_we(b_d_we), .d_addr(b_d_addr), .d_wdata(b_d_wdata),
        .d_wmask(b_d_wmask), .d_ready(b_d_ready), .d_rvalid(b_d_rvalid),
        .d_bvalid(b_d_bvalid), .d_rdata(b_d_rdata),
        .io_sram_en(b_en), .io_sram_we(b_we), .io_sram_addr(b_addr),
        .io_sram_din(b_din), .io_sram_wmask(b_wmask), .io_sram_dout(b_dout)
    );

    // SRAM model A: 256 words, word 0x10 holds DEADBEEF, others {4{addr}}.
    logic [31:0] mem_a [256];
    logic        mem_init = 1'b0;
    always @(posedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < 256; i++)
                mem_a[i] <= (i == 16) ? 32'hDEADBEEF : {4{8'(i)}};
            mem_init <= 1'b1;
        end else if (a_en && a_we) begin
            for (int k = 0; k < 4; k++)
                if (a_wmask[k]) mem_a[a_addr[7:0]][8*k +: 8] <= a_din[8*k +: 8];
        end
    end
    assign a_dout = mem_a[a_addr[7:0]];

    // SRAM model B: read-only pattern.
    assign b_dout = b_en ? {4{b_addr[7:0]}} : 32'h0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
        #1;
    endtask

    exp_t q_a[$];
    exp_t q_b[$];
    logic grant_b[$];
    int   cnt_bi = 0, cnt_bd = 0;

    always @(negedge clk) begin : mon_a
        exp_t e;
        int   np;
        if (!resetn) begin
            q_a.delete();
        end else begin
            if (a_i_req && a_i_ready) q_a.push_back('{1'b0, 1'b0, mem_a[a_i_addr[7:0]]});
            if (a_d_req && a_d_ready)
                q_a.push_back('{1'b1, a_d_we, a_d_we ? 32'h0 : mem_a[a_d_addr[7:0]]});
            np = int'(a_i_rvalid) + int'(a_d_rvalid) + int'(a_d_bvalid);
            if (np != 0) begin
                chk("a_one_pulse", np, 1);
                chk("a_sb_pending", q_a.size() != 0, 1);
                if (q_a.size() != 0) begin
                    e = q_a.pop_front();
                    chk("a_port", a_d_rvalid | a_d_bvalid, e.port);
                    chk("a_kind", a_d_bvalid, e.we);
                    if (!e.we) chk("a_rdata", a_i_rvalid ? a_i_rdata : a_d_rdata, e.data);
                    $display("A completion port=%0d we=%0d data=%h", e.port, e.we, e.data);
                end
            end
        end
    end

    always @(negedge clk) begin : mon_b
        exp_t e;
        int   np;
        if (!resetn) begin
            q_b.delete();
        end else begin
            if (b_en) chk("b_we_low", {b_we, b_wmask, b_din}, 0);
            if (b_i_req && b_i_ready) begin
                q_b.push_back('{1'b0, 1'b0, {4{b_i_addr[7:0]}}});
                grant_b.push_back(1'b0);
            end
            if (b_d_req && b_d_ready) begin
                q_b.push_back('{1'b1, 1'b0, {4{b_d_addr[7:0]}}});
                grant_b.push_back(1'b1);
            end
            np = int'(b_i_rvalid) + int'(b_d_rvalid) + int'(b_d_bvalid);
            if (np != 0) begin
                chk("b_one_pulse", np, 1);
                chk("b_sb_pending", q_b.size() != 0, 1);
                if (q_b.size() != 0) begin
                    e = q_b.pop_front();
                    chk("b_port", b_d_rvalid, e.port);
                    chk("b_rdata", b_i_rvalid ? b_i_rdata : b_d_rdata, e.data);
                    if (b_i_rvalid) cnt_bi++;
                    if (b_d_rvalid) cnt_bd++;
                    $display("B completion port=%0d data=%h", e.port, e.data);
                end
            end
        end
    end

    initial begin
        bit got;

        // Reset values
        repeat (2) mid();
        chk("rst_en", a_en, 0);
        chk("rst_bus", {a_we, a_addr, a_din, a_wmask}, 0);
        chk("rst_pulses", {a_i_rvalid, a_d_rvalid, a_d_bvalid}, 0);
        chk("rst_rdata", {a_i_rdata, a_d_rdata}, 0);
        tick(); resetn = 1'b1;
        tick();

        // Single I read of 0x10
        tick(); a_i_req = 1; a_i_addr = 20'h10;
        mid();  chk("t1_iready", a_i_ready, 1);
        tick(); a_i_req = 0;
        mid();  chk("t1_en1", a_en, 1); chk("t1_addr", a_addr, 20'h10); chk("t1_we", a_we, 0);
        tick(); mid(); chk("t1_en2", a_en, 1);
        tick(); mid(); chk("t1_rvalid", a_i_rvalid, 1); chk("t1_rdata", a_i_rdata, 32'hDEADBEEF);
        chk("t1_en_off", a_en, 0);

        // D write with mask 0101, then I read blocked by TURN
        tick(); a_d_req = 1; a_d_we = 1; a_d_addr = 20'h20; a_d_wdata = 32'h11223344; a_d_wmask = 4'b0101;
        mid();  chk("t2_dready", a_d_ready, 1);
        tick(); a_d_req = 0;
        mid();  chk("t2_we1", {a_en, a_we, a_wmask}, {1'b1, 1'b1, 4'b0101}); chk("t2_din", a_din, 32'h11223344);
        tick(); mid(); chk("t2_we2", {a_en, a_we, a_wmask}, {1'b1, 1'b1, 4'b0101});
        tick(); a_i_req = 1; a_i_addr = 20'h14;
        mid();  chk("t2_bvalid", a_d_bvalid, 1); chk("t2_turn_block", a_i_ready, 0); chk("t2_en_off", a_en, 0);
        tick(); mid(); chk("t2_accept_after_turn", a_i_ready, 1);
        tick(); a_i_req = 0;
        tick(); tick(); mid(); chk("t2_rd_done", a_i_rvalid, 1); chk("t2_rd_data", a_i_rdata, 32'h14141414);
        chk("t2_mem", mem_a[8'h20], 32'h20222044);

        // Zero-mask write still completes and leaves memory untouched
        tick(); a_d_req = 1; a_d_we = 1; a_d_addr = 20'h21; a_d_wmask = 4'b0000;
        tick(); a_d_req = 0;
        got = 0;
        for (int k = 0; k < 10 && !got; k++) begin mid(); got = a_d_bvalid; if (!got) tick(); end
        chk("t2b_bvalid", got, 1);
        chk("t2b_mem", mem_a[8'h21], 32'h21212121);
        tick(); tick();

        // Simultaneous requests, D priority
        tick(); a_i_req = 1; a_i_addr = 20'h30; a_d_req = 1; a_d_we = 0; a_d_addr = 20'h40;
        mid();  chk("t3_d_first", {a_d_ready, a_i_ready}, 2'b10);
        tick(); a_d_req = 0;
        mid();  chk("t3_i_wait", a_i_ready, 0);
        tick(); mid();
        tick(); mid(); chk("t3_drvalid", a_d_rvalid, 1); chk("t3_drdata", a_d_rdata, 32'h40404040);
        chk("t3_i_accept", a_i_ready, 1);
        tick(); a_i_req = 0;
        tick(); tick(); mid(); chk("t3_irvalid", a_i_rvalid, 1); chk("t3_irdata", a_i_rdata, 32'h30303030);

        // Back-to-back I reads
        tick(); a_i_req = 1; a_i_addr = 20'h1;
        mid();  chk("t5_ready1", a_i_ready, 1);
        tick(); mid(); chk("t5_en_a", a_en, 1);
        tick(); mid(); chk("t5_en_b", a_en, 1);
        tick(); a_i_addr = 20'h2;
        mid();  chk("t5_rvalid1", a_i_rvalid, 1); chk("t5_rdata1", a_i_rdata, 32'h01010101);
        chk("t5_gap", a_en, 0); chk("t5_ready2", a_i_ready, 1);
        tick(); a_i_req = 0;
        mid();  chk("t5_en_c", a_en, 1); chk("t5_addr2", a_addr, 20'h2);
        tick(); tick(); mid(); chk("t5_rdata2", a_i_rdata, 32'h02020202);

        // Reset in the middle of a D read
        tick(); a_d_req = 1; a_d_we = 0; a_d_addr = 20'h50;
        tick(); a_d_req = 0;
        mid();  chk("t6_en_before", a_en, 1);
        resetn = 1'b0; #1;
        chk("t6_en_async", a_en, 0); chk("t6_addr_async", a_addr, 0);
        tick(); mid(); chk("t6_no_rvalid1", a_d_rvalid, 0);
        tick(); mid(); chk("t6_no_rvalid2", a_d_rvalid, 0);
        tick(); resetn = 1'b1;
        mid();  chk("t6_bus", {a_en, a_we, a_addr, a_din, a_wmask}, 0);
        chk("t6_rdata", {a_i_rdata, a_d_rdata}, 0);
        chk("t6_pulses", {a_i_rvalid, a_d_rvalid, a_d_bvalid}, 0);
        tick(); a_i_req = 1; a_i_addr = 20'h60;
        mid();  chk("t6_iready", a_i_ready, 1);
        tick(); a_i_req = 0;
        got = 0;
        for (int k = 0; k < 10 && !got; k++) begin mid(); got = a_i_rvalid; if (!got) tick(); end
        chk("t6_rvalid", got, 1);
        chk("t6_rdata_after", a_i_rdata, 32'h60606060);

        // Round-robin on instance B
        tick(); b_i_req = 1; b_i_addr = 20'h3; b_d_req = 1; b_d_we = 0; b_d_addr = 20'h4;
        for (int k = 0; k < 100 && grant_b.size() < 6; k++) begin mid(); tick(); end
        b_i_req = 0; b_d_req = 0;
        repeat (6) tick();
        mid();
        chk("rr_accepts", grant_b.size(), 6);
        for (int k = 0; k < 6 && k < grant_b.size(); k++) chk("rr_order", grant_b[k], k % 2);
        chk("rr_i_done", cnt_bi, 3);
        chk("rr_d_done", cnt_bd, 3);

        chk("a_sb_drained", q_a.size(), 0);
        chk("b_sb_drained", q_b.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
- Sequences the single-ported external SRAM (via the io_sram_* request bus of the SRAM pin wrapper) and shares it between two requesters: the instruction-fetch port (I, read-only) and the data port (D, read/write).
- Accepts one request at a time through a valid/ready handshake.
- Holds the SRAM request stable for a fixed number of cycles, captures read data, and returns a one-cycle completion pulse to the owning port.
- Sits between the core's fetch/LSU stages and the SRAM wrapper.

Parameters:
- ADDR_W, 20, SRAM word-address width.
- DATA_W, 32, data width. DATA_W/8 byte lanes.
- ACCESS_CYCLES, 2, cycles io_sram_en is held per access. Must be at least 1; 0 is an elaboration error.
- DPRIO, 1. 1 = D port has fixed priority. 0 = round-robin.

Ports:
- clock  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- i_req  in  1  I-port read request
- i_addr  in  ADDR_W  I-port address
- i_ready  out  1  I-port request accepted this cycle
- i_rvalid  out  1  I-port read-data-valid pulse
- i_rdata  out  DATA_W  I-port read data
- d_req  in  1  D-port request
- d_we  in  1  D-port write (1) / read (0)
- d_addr  in  ADDR_W  D-port address
- d_wdata  in  DATA_W  D-port write data
- d_wmask  in  DATA_W/8  D-port byte mask, 1 = write lane
- d_ready  out  1  D-port request accepted this cycle
- d_rvalid  out  1  D-port read-data-valid pulse
- d_bvalid  out  1  D-port write-done pulse
- d_rdata  out  DATA_W  D-port read data
- io_sram_en  out  1  SRAM access enable
- io_sram_we  out  1  SRAM write
- io_sram_addr  out  ADDR_W  SRAM address
- io_sram_din  out  DATA_W  SRAM write data
- io_sram_wmask  out  DATA_W/8  SRAM byte mask
- io_sram_dout  in  DATA_W  SRAM read data

Behaviour:
- Reset values:
  - All pulses, io_sram_en and io_sram_we are 0.
  - Address, data and mask outputs are 0.
  - i_rdata and d_rdata are 0.
  - State is IDLE; cycle counter is 0; last_grant = D, so in round-robin mode I wins the first tie.
- States:
  - IDLE: SRAM idle.
  - ACCESS: io_sram_en = 1.
  - TURN: one idle cycle after every write, for bus turnaround.
- Handshake:
  - i_ready and d_ready are combinational.
  - At most one of them is 1, and only in IDLE, for the port the arbiter selects among those with req = 1.
  - A request is accepted when req && ready. Its fields are registered that cycle.
  - A requester holds its fields stable while req = 1 and ready = 0.
- Arbitration:
  - If only one port requests, that port wins.
  - If both request and DPRIO = 1, D wins.
  - If both request and DPRIO = 0, the port not equal to last_grant wins. last_grant updates on each accept.
- Timing for a request accepted at cycle T:
  - io_sram_en = 1 on cycles T+1 .. T+ACCESS_CYCLES. Outputs are registered and stay constant across the window.
  - For reads: io_sram_we = 0, io_sram_wmask = 0, io_sram_din = 0.
  - Read: io_sram_dout is sampled on the last ACCESS cycle into the owner's rdata register. The owner's rvalid = 1 for exactly cycle T+ACCESS_CYCLES+1. State is IDLE in that cycle, so a new accept is possible at T+ACCESS_CYCLES+1.
  - Write: d_bvalid = 1 for exactly cycle T+ACCESS_CYCLES+1, and state is TURN in that cycle. State returns to IDLE at T+ACCESS_CYCLES+2.
- A write with d_wmask = 0 still performs the full cycle sequence and pulses d_bvalid.
- i_rdata / d_rdata hold their value until that port's next read completes.
- The counter is sized clog2(ACCESS_CYCLES+1) and saturates at no point: it is reloaded on each accept.
- No more than one rvalid/bvalid pulse is 1 in any cycle.
- Reset mid-access: resetn low clears all state asynchronously.
  - io_sram_en drops immediately.
  - The aborted access produces no completion pulse.
  - Requesters must re-issue the request after reset.
- req deasserted after acceptance has no effect on the access in flight.

Decomposition:
- Package sram_arb_pkg holds:
  - state enum {IDLE, ACCESS, TURN};
  - port-id enum {PORT_I, PORT_D};
  - default width constants.
- Sub-module sram_rr_arbiter: two-way fixed-priority/round-robin selector. Inputs: req vector, last_grant, DPRIO. Output: one-hot grant.

Test Plan:
- Single I read, ACCESS_CYCLES = 2: i_req at T, addr 0x00010, SRAM model returns 0xDEADBEEF.
  -> i_ready = 1 at T; io_sram_en = 1 at T+1..T+2; i_rvalid = 1 at T+3 with i_rdata = 0xDEADBEEF.
- D write: addr 0x00020, data 0x11223344, mask 4'b0101.
  -> io_sram_we = 1 and io_sram_wmask = 4'b0101 for 2 cycles; d_bvalid at T+3; TURN at T+3; next accept no earlier than T+4; model memory bytes 0 and 2 updated only.
- Simultaneous i_req and d_req (read), DPRIO = 1.
  -> D served first; I accepted at the cycle of d_rvalid; completion pulses never coincide.
- DPRIO = 0, both ports requesting continuously for 6 accesses.
  -> grants alternate I, D, I, D, I, D; each port receives exactly 3 completions.
- Back-to-back I reads: 0x1, then 0x2.
  -> second accept in the same cycle as the first i_rvalid; io_sram_en continuous except one gap cycle.
- resetn pulsed low in the middle of a D read's ACCESS window.
  -> io_sram_en = 0 immediately; no d_rvalid; after release, outputs match reset values and a new I read completes normally.
